// File: rtl/mont_pkg.sv
// Shared definitions for the modular exponentiation engine and its Montgomery multiplier.
package mont_pkg;

  localparam int DEF_WIDTH   = 512;
  localparam int DEF_E_WIDTH = 512;

  typedef enum logic [2:0] {
    IDLE = 3'd0,
    PRE  = 3'd1,
    SQ   = 3'd2,
    MUL  = 3'd3,
    POST = 3'd4,
    DONE = 3'd5
  } state_t;

endpackage

// File: rtl/mont_mul.sv
// Bit-serial radix-2 Montgomery multiplier: result = a*b*2^-WIDTH mod m, for a,b < m, m odd.
// Operands are read directly from the inputs, which the caller holds stable while running.
module mont_mul #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             resetn,
  input  logic             start,
  input  logic [WIDTH-1:0] in_a,
  input  logic [WIDTH-1:0] in_b,
  input  logic [WIDTH-1:0] in_m,
  output logic [WIDTH-1:0] result,
  output logic             done
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  logic             run;
  logic             fin;
  logic [CNT_W-1:0] cnt;
  logic [WIDTH+1:0] t;
  logic [WIDTH+1:0] s_add;
  logic [WIDTH+1:0] s_red;
  logic [WIDTH+1:0] t_sub;
  logic             unused_sub_hi;

  // Partial sum stays below 4m, so two guard bits are enough.
  always_comb begin
    s_add = t + (in_a[cnt] ? {2'b00, in_b} : '0);
    s_red = s_add[0] ? (s_add + {2'b00, in_m}) : s_add;
    t_sub = t - {2'b00, in_m};
  end

  assign unused_sub_hi = ^t_sub[WIDTH+1:WIDTH];

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      run    <= 1'b0;
      fin    <= 1'b0;
      cnt    <= '0;
      t      <= '0;
      result <= '0;
      done   <= 1'b0;
    end else begin
      done <= 1'b0;
      if (start) begin
        run <= 1'b1;
        fin <= 1'b0;
        cnt <= '0;
        t   <= '0;
      end else if (run) begin
        t <= s_red >> 1;
        if (cnt == CNT_W'(WIDTH - 1)) begin
          run <= 1'b0;
          fin <= 1'b1;
        end else begin
          cnt <= cnt + CNT_W'(1);
        end
      end else if (fin) begin
        fin    <= 1'b0;
        done   <= 1'b1;
        result <= (t >= {2'b00, in_m}) ? t_sub[WIDTH-1:0] : t[WIDTH-1:0];
      end
    end
  end

endmodule

// File: rtl/mont_exp_param.sv
// Modular exponentiation x^e mod m by left-to-right square-and-multiply in the Montgomery domain,
// sequencing a single mont_mul instance.
module mont_exp_param
  import mont_pkg::*;
#(
  parameter  int WIDTH   = DEF_WIDTH,
  parameter  int E_WIDTH = DEF_E_WIDTH,
  localparam int LEN_W   = $clog2(E_WIDTH + 1)
) (
  input  logic               clk,
  input  logic               resetn,
  input  logic               start,
  input  logic [WIDTH-1:0]   in_x,
  input  logic [WIDTH-1:0]   in_m,
  input  logic [E_WIDTH-1:0] in_e,
  input  logic [LEN_W-1:0]   in_elen,
  input  logic [WIDTH-1:0]   in_r,
  input  logic [WIDTH-1:0]   in_r2,
  output logic               busy,
  output logic               done,
  output logic [WIDTH-1:0]   result
);

  localparam int IDX_W = (E_WIDTH > 1) ? $clog2(E_WIDTH) : 1;

  state_t             state;
  state_t             state_nxt;
  logic               mm_go;
  logic               accept;
  logic               last_bit;

  logic [WIDTH-1:0]   x_q;
  logic [WIDTH-1:0]   m_q;
  logic [E_WIDTH-1:0] e_q;
  logic [WIDTH-1:0]   r_q;
  logic [WIDTH-1:0]   r2_q;
  logic [LEN_W-1:0]   elen_q;
  logic [LEN_W-1:0]   elen_clamp;
  logic [IDX_W-1:0]   idx;
  logic [WIDTH-1:0]   a_q;
  logic [WIDTH-1:0]   xt_q;

  logic               mm_start;
  logic               mm_done;
  logic [WIDTH-1:0]   mm_a;
  logic [WIDTH-1:0]   mm_b;
  logic [WIDTH-1:0]   mm_res;

  assign elen_clamp = (in_elen > LEN_W'(E_WIDTH)) ? LEN_W'(E_WIDTH) : in_elen;
  assign last_bit   = (idx == '0);

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) state <= IDLE;
    else         state <= state_nxt;
  end

  // mm_go marks entry into a multiplication state, including SQ re-entering itself.
  always_comb begin
    state_nxt = state;
    mm_go     = 1'b0;
    accept    = 1'b0;
    case (state)
      IDLE, DONE: begin
        if (start) begin
          accept    = 1'b1;
          mm_go     = 1'b1;
          state_nxt = PRE;
        end
      end
      PRE: begin
        if (mm_done) begin
          mm_go     = 1'b1;
          state_nxt = (elen_q == '0) ? POST : SQ;
        end
      end
      SQ: begin
        if (mm_done) begin
          mm_go = 1'b1;
          if (e_q[idx]) state_nxt = MUL;
          else          state_nxt = last_bit ? POST : SQ;
        end
      end
      MUL: begin
        if (mm_done) begin
          mm_go     = 1'b1;
          state_nxt = last_bit ? POST : SQ;
        end
      end
      POST: begin
        if (mm_done) state_nxt = DONE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      x_q      <= '0;
      m_q      <= '0;
      e_q      <= '0;
      r_q      <= '0;
      r2_q     <= '0;
      elen_q   <= '0;
      idx      <= '0;
      a_q      <= '0;
      xt_q     <= '0;
      result   <= '0;
      busy     <= 1'b0;
      done     <= 1'b0;
      mm_start <= 1'b0;
    end else begin
      mm_start <= mm_go;
      if (accept) begin
        x_q    <= in_x;
        m_q    <= in_m;
        e_q    <= in_e;
        r_q    <= in_r;
        r2_q   <= in_r2;
        elen_q <= elen_clamp;
        busy   <= 1'b1;
        done   <= 1'b0;
      end
      case (state)
        PRE: if (mm_done) begin
          xt_q <= mm_res;
          a_q  <= r_q;
          idx  <= IDX_W'(elen_q - LEN_W'(1));
        end
        SQ: if (mm_done) begin
          a_q <= mm_res;
          if (!e_q[idx] && !last_bit) idx <= idx - IDX_W'(1);
        end
        MUL: if (mm_done) begin
          a_q <= mm_res;
          if (!last_bit) idx <= idx - IDX_W'(1);
        end
        POST: if (mm_done) begin
          result <= mm_res;
          busy   <= 1'b0;
          done   <= 1'b1;
        end
        default: ;
      endcase
    end
  end

  // Multiplying by plain 1 in POST converts A back out of the Montgomery domain.
  always_comb begin
    mm_a = '0;
    mm_b = '0;
    case (state)
      PRE:  begin mm_a = x_q; mm_b = r2_q;        end
      SQ:   begin mm_a = a_q; mm_b = a_q;         end
      MUL:  begin mm_a = a_q; mm_b = xt_q;        end
      POST: begin mm_a = a_q; mm_b = WIDTH'(1);   end
      default: ;
    endcase
  end

  mont_mul #(
    .WIDTH (WIDTH)
  ) u_mont_mul (
    .clk    (clk),
    .resetn (resetn),
    .start  (mm_start),
    .in_a   (mm_a),
    .in_b   (mm_b),
    .in_m   (m_q),
    .result (mm_res),
    .done   (mm_done)
  );

endmodule
